// File: rtl/dm_pkg.sv
// dm_pkg: shared types and helpers for the MEM-stage data-memory unit.
//   - access size encodings (size_e)
//   - clear-engine FSM state type (state_e)
//   - be_gen():        byte-lane enable mask for an access
//   - is_misaligned(): illegal size/alignment combination detection
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Lane enables for an access of the given size at byte offset lane.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Half needs even offset, word needs offset 0, the reserved size is never legal.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      SZ_WORD: mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_ram.sv
// dm_ram: single-port 32-bit RAM with per-byte write enables and a
// registered read port, written so it maps onto block RAM.
//   clk    in  clock
//   we     in  [3:0]  byte-lane write enables
//   addr   in  [ADDR_W-1:0] word address
//   wdata  in  [31:0] write data (already lane-replicated)
//   re     in  read enable; the output register only loads when set
//   rdata  out [31:0] registered read word, holds when re=0
module dm_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              re,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rdata_q;

  // Byte-lane writes and the registered read; no reset so it stays BRAM-mappable.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_unit.sv
// dm_unit: data-memory unit for the MEM stage.
//   clk, rst   clock, asynchronous active-high reset
//   en, we     access request / store select
//   size, sext access size (00 byte, 01 half, 10 word) and load extension
//   addr       byte address (word index = addr[ADDR_W+1:2], upper bits ignored)
//   wdata      right-justified store data
//   intr       interrupt taken this cycle; blocks the store only
//   rdata      load result, valid the cycle after an accepted aligned load
//   busy       post-reset clear engine running; accesses ignored
//   misalign   one-cycle pulse after an illegal access
module dm_unit
  import dm_pkg::*;
#(
  parameter int ADDR_W       = 11,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        intr,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        misalign
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam state_e            RST_ST   = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              misalign_q, misalign_d;
  logic              vld_q, vld_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;

  logic              acc_ok;
  logic              mis;
  logic              store_ok;
  logic              load_ok;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       st_data;
  logic              addr_unused;

  assign addr_unused = ^addr[31:ADDR_W+2];

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: r = {{24{sx & b[7]}}, b};
      SZ_HALF: r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign busy     = (state_q == ST_CLEAR);
  assign acc_ok   = en & ~busy;
  assign mis      = is_misaligned(size, addr[1:0]);
  // rst gate: a store racing an asserting reset must not land in the array.
  assign store_ok = acc_ok & we & ~intr & ~mis & ~rst;
  assign load_ok  = acc_ok & ~we & ~mis;

  // Clear-engine next state and word counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // RAM port steering: the clear engine owns the port while busy.
  always_comb begin
    st_data   = 32'h0000_0000;
    ram_we    = 4'b0000;
    ram_addr  = addr[ADDR_W+1:2];
    ram_wdata = 32'h0000_0000;
    case (size)
      SZ_BYTE: st_data = {4{wdata[7:0]}};
      SZ_HALF: st_data = {2{wdata[15:0]}};
      default: st_data = wdata;
    endcase
    if (busy) begin
      ram_we    = rst ? 4'b0000 : 4'b1111;
      ram_addr  = cnt_q;
      ram_wdata = 32'h0000_0000;
    end else if (store_ok) begin
      ram_we    = be_gen(size, addr[1:0]);
      ram_addr  = addr[ADDR_W+1:2];
      ram_wdata = st_data;
    end else begin
      ram_we    = 4'b0000;
      ram_addr  = addr[ADDR_W+1:2];
      ram_wdata = st_data;
    end
  end

  // Load-side bookkeeping captured alongside the RAM read, plus the misalign pulse.
  always_comb begin
    misalign_d = acc_ok & mis;
    vld_d      = vld_q;
    lane_d     = lane_q;
    size_d     = size_q;
    sext_d     = sext_q;
    if (load_ok) begin
      vld_d  = 1'b1;
      lane_d = addr[1:0];
      size_d = size;
      sext_d = sext;
    end else begin
      vld_d  = vld_q;
    end
  end

  // State, counter and load-context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_ST;
      cnt_q      <= {ADDR_W{1'b0}};
      misalign_q <= 1'b0;
      vld_q      <= 1'b0;
      lane_q     <= 2'b00;
      size_q     <= SZ_WORD;
      sext_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      vld_q      <= vld_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
    end
  end

  dm_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .re    (load_ok),
    .rdata (ram_rdata)
  );

  // The RAM output register has no reset; vld_q forces the post-reset value to 0
  // until the first load lands. Everything feeding extract() is a flop output.
  assign rdata    = vld_q ? extract(ram_rdata, lane_q, size_q, sext_q) : 32'h0000_0000;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_unit.sv
module tb_dm_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        intr;
  logic [31:0] rdata;
  logic        busy;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        intr;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[22];

  dm_unit #(.ADDR_W(4), .CLEAR_ON_RST(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .we       (we),
    .size     (size),
    .sext     (sext),
    .addr     (addr),
    .wdata    (wdata),
    .intr     (intr),
    .rdata    (rdata),
    .busy     (busy),
    .misalign (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic e, input logic w, input logic [1:0] s, input logic sx,
                              input logic [31:0] a, input logic [31:0] d, input logic i,
                              input logic [31:0] er, input logic em);
    vec_t v;
    v.en = e; v.we = w; v.size = s; v.sext = sx; v.addr = a; v.wdata = d; v.intr = i;
    v.exp_rdata = er; v.exp_mis = em;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, let one edge pass, check at the following negedge.
  task automatic apply(input vec_t v, input string name);
    en = v.en; we = v.we; size = v.size; sext = v.sext;
    addr = v.addr; wdata = v.wdata; intr = v.intr;
    @(posedge clk);
    @(negedge clk);
    check({name, " rdata"}, rdata, v.exp_rdata);
    check({name, " misalign"}, {31'd0, misalign}, {31'd0, v.exp_mis});
  endtask

  // Count cycles with busy high (bounded); optionally inject a store and a
  // misaligned access while busy, both of which must be ignored.
  task automatic clear_count(input bit inject, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      if (inject && n == 10) begin
        en = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h0; wdata = 32'hFFFF_FFFF; intr = 1'b0;
      end else if (inject && n == 12) begin
        en = 1'b1; we = 1'b0; size = 2'b01; addr = 32'h1;
      end else begin
        en = 1'b0; we = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
      if (inject) check("busy misalign", {31'd0, misalign}, 32'd0);
    end
    en = 1'b0; we = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; we = 1'b0; size = 2'b00; sext = 1'b0;
    addr = 32'h0; wdata = 32'h0; intr = 1'b0;

    // byte-addressed stimulus; expected values worked out by hand
    tbl[0]  = mk(1, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h00000000, 0);
    tbl[1]  = mk(1, 0, 2'b00, 1, 32'h13, 32'h0,        0, 32'hFFFFFFDE, 0);
    tbl[2]  = mk(1, 0, 2'b00, 0, 32'h12, 32'h0,        0, 32'h000000AD, 0);
    tbl[3]  = mk(1, 0, 2'b00, 1, 32'h10, 32'h0,        0, 32'hFFFFFFEF, 0);
    tbl[4]  = mk(1, 0, 2'b01, 0, 32'h12, 32'h0,        0, 32'h0000DEAD, 0);
    tbl[5]  = mk(1, 1, 2'b01, 0, 32'h22, 32'h00008001, 0, 32'h0000DEAD, 0);
    tbl[6]  = mk(1, 0, 2'b01, 1, 32'h22, 32'h0,        0, 32'hFFFF8001, 0);
    tbl[7]  = mk(1, 0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h80010000, 0);
    tbl[8]  = mk(1, 0, 2'b01, 0, 32'h20, 32'h0,        0, 32'h00000000, 0);
    tbl[9]  = mk(1, 1, 2'b10, 0, 32'h05, 32'hCAFEF00D, 0, 32'h00000000, 1);
    tbl[10] = mk(1, 0, 2'b01, 1, 32'h01, 32'h0,        0, 32'h00000000, 1);
    tbl[11] = mk(1, 0, 2'b10, 0, 32'h04, 32'h0,        0, 32'h00000000, 0);
    tbl[12] = mk(1, 0, 2'b11, 0, 32'h10, 32'h0,        0, 32'h00000000, 1);
    tbl[13] = mk(1, 1, 2'b10, 0, 32'h30, 32'h12345678, 1, 32'h00000000, 0);
    tbl[14] = mk(1, 0, 2'b10, 0, 32'h30, 32'h0,        0, 32'h00000000, 0);
    tbl[15] = mk(1, 1, 2'b10, 0, 32'h30, 32'h12345678, 0, 32'h00000000, 0);
    tbl[16] = mk(1, 0, 2'b10, 0, 32'h30, 32'h0,        1, 32'h12345678, 0);
    tbl[17] = mk(1, 0, 2'b10, 0, 32'h70, 32'h0,        0, 32'h12345678, 0);
    tbl[18] = mk(1, 1, 2'b00, 0, 32'h31, 32'hFFFFFFA5, 0, 32'h12345678, 0);
    tbl[19] = mk(1, 0, 2'b10, 0, 32'h30, 32'h0,        0, 32'h1234A578, 0);
    tbl[20] = mk(0, 0, 2'b00, 1, 32'h13, 32'h0,        0, 32'h1234A578, 0);
    tbl[21] = mk(1, 0, 2'b01, 1, 32'h32, 32'h0,        0, 32'h00001234, 0);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd1);
    check("reset rdata", rdata, 32'h0);
    check("reset misalign", {31'd0, misalign}, 32'd0);
    rst = 1'b0;

    clear_count(1'b0, n);
    check("clear length", n, 32'd16);

    for (int w = 0; w < 16; w++) begin
      apply(mk(1, 0, 2'b10, 0, w * 4, 32'h0, 0, 32'h0, 0), $sformatf("cleared w%0d", w));
    end

    for (int i = 0; i < 22; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end
    en = 1'b0;

    // reset mid-access: outputs drop immediately
    rst = 1'b1;
    #1;
    check("async rst rdata", rdata, 32'h0);
    check("async rst busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // let the clear run 7 cycles, then reset again mid-clear
    repeat (7) @(negedge clk);
    check("mid-clear busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_count(1'b1, n);
    check("restart clear length", n, 32'd16);

    apply(mk(1, 0, 2'b10, 0, 32'h00, 32'h0, 0, 32'h0, 0), "dropped store w0");
    apply(mk(1, 0, 2'b10, 0, 32'h20, 32'h0, 0, 32'h0, 0), "recleared w8");
    apply(mk(1, 0, 2'b10, 0, 32'h30, 32'h0, 0, 32'h0, 0), "recleared w12");
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
